// File: rtl/riscv_div_seq.sv
// Iterative radix-2 divider with sequencing FSM for the RV64 execute stage.
// Handles DIV/DIVU/REM/REMU and their W forms, with flush and stall support.
module riscv_div_seq #(
  parameter int XLEN = 64,
  parameter int CNTW = 6
) (
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  input  logic            i_riscv_div_valid,
  input  logic [1:0]      i_riscv_div_op,
  input  logic            i_riscv_div_word,
  input  logic [XLEN-1:0] i_riscv_div_rs1data,
  input  logic [XLEN-1:0] i_riscv_div_rs2data,
  input  logic            i_riscv_div_kill,
  output logic            o_riscv_div_stall,
  output logic            o_riscv_div_done,
  output logic [XLEN-1:0] o_riscv_div_result
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic            op_rem_q;
  logic            word_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  function automatic logic [XLEN-1:0] fold(
    input logic            w,
    input logic [XLEN-1:0] x
  );
    fold = w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  logic            is_signed;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic            div_zero;
  logic            ovf;
  logic            special;
  logic [XLEN-1:0] spec_raw;
  logic            accept;

  assign is_signed = ~i_riscv_div_op[0];

  always_comb begin
    a_ext = i_riscv_div_rs1data;
    b_ext = i_riscv_div_rs2data;
    if (i_riscv_div_word) begin
      a_ext = {{(XLEN-32){is_signed & i_riscv_div_rs1data[31]}},
               i_riscv_div_rs1data[31:0]};
      b_ext = {{(XLEN-32){is_signed & i_riscv_div_rs2data[31]}},
               i_riscv_div_rs2data[31:0]};
    end
  end

  assign a_neg    = is_signed & a_ext[XLEN-1];
  assign b_neg    = is_signed & b_ext[XLEN-1];
  assign a_abs    = a_neg ? -a_ext : a_ext;
  assign b_abs    = b_neg ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);

  // Most-negative / -1 at the op width; the W check ignores upper bits.
  always_comb begin
    if (i_riscv_div_word)
      ovf = is_signed
          & (i_riscv_div_rs1data[31:0] == 32'h8000_0000)
          & (i_riscv_div_rs2data[31:0] == 32'hFFFF_FFFF);
    else
      ovf = is_signed
          & (i_riscv_div_rs1data == {1'b1, {(XLEN-1){1'b0}}})
          & (i_riscv_div_rs2data == '1);
  end

  assign special = div_zero | ovf;

  always_comb begin
    if (i_riscv_div_op[1])
      spec_raw = div_zero ? a_ext : '0;
    else
      spec_raw = div_zero ? '1 : a_ext;
  end

  assign accept = (state == IDLE) & i_riscv_div_valid & ~i_riscv_div_kill;

  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] dvd_nxt;
  logic [XLEN-1:0] quo_fin;
  logic [XLEN-1:0] rem_fin;
  logic [XLEN-1:0] calc_res;
  logic            last;

  // Dividend shifts out of dvd_q MSB-first while quotient bits shift in.
  assign rem_sh  = {rem_q, dvd_q[XLEN-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign dvd_nxt = {dvd_q[XLEN-2:0], q_bit};

  assign quo_fin  = neg_quo_q ? -dvd_nxt : dvd_nxt;
  assign rem_fin  = neg_rem_q ? -rem_nxt : rem_nxt;
  assign calc_res = fold(word_q, op_rem_q ? rem_fin : quo_fin);
  assign last     = (cnt == CNTW'(word_q ? XLEN/2-1 : XLEN-1));

  assign o_riscv_div_stall = ~i_riscv_rst & ~i_riscv_div_kill
                           & (((state == IDLE) & i_riscv_div_valid)
                             | (state == CALC));

  always_ff @(posedge i_riscv_clk) begin
    if (i_riscv_rst) begin
      state              <= IDLE;
      cnt                <= '0;
      rem_q              <= '0;
      dvd_q              <= '0;
      dvs_q              <= '0;
      op_rem_q           <= 1'b0;
      word_q             <= 1'b0;
      neg_quo_q          <= 1'b0;
      neg_rem_q          <= 1'b0;
      o_riscv_div_done   <= 1'b0;
      o_riscv_div_result <= '0;
    end else begin
      o_riscv_div_done <= 1'b0;
      if (i_riscv_div_kill) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              op_rem_q  <= i_riscv_div_op[1];
              word_q    <= i_riscv_div_word;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
              dvs_q     <= b_abs;
              rem_q     <= '0;
              cnt       <= '0;
              if (i_riscv_div_word)
                dvd_q <= {a_abs[31:0], {(XLEN-32){1'b0}}};
              else
                dvd_q <= a_abs;
              if (special) begin
                o_riscv_div_result <= fold(i_riscv_div_word, spec_raw);
                o_riscv_div_done   <= 1'b1;
                state              <= DONE;
              end else begin
                state <= CALC;
              end
            end
          end
          CALC: begin
            rem_q <= rem_nxt;
            dvd_q <= dvd_nxt;
            cnt   <= cnt + CNTW'(1);
            if (last) begin
              o_riscv_div_result <= calc_res;
              o_riscv_div_done   <= 1'b1;
              state              <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_div_seq.sv
// Directed bench for riscv_div_seq: vector table plus kill/reset sequences.
// Checks latency, stall window and result for every operation.
module tb_riscv_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  op;
  logic        word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        kill;
  logic        stall;
  logic        done;
  logic [63:0] result;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] last_res = '0;

  riscv_div_seq dut (
    .i_riscv_clk         (clk),
    .i_riscv_rst         (rst),
    .i_riscv_div_valid   (valid),
    .i_riscv_div_op      (op),
    .i_riscv_div_word    (word),
    .i_riscv_div_rs1data (rs1),
    .i_riscv_div_rs2data (rs2),
    .i_riscv_div_kill    (kill),
    .o_riscv_div_stall   (stall),
    .o_riscv_div_done    (done),
    .o_riscv_div_result  (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    int          cyc;
    logic [63:0] res;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // abort_cyc = 0: normal run; otherwise kill (or reset) in that cycle.
  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic w, input logic [63:0] a,
                        input logic [63:0] b, input int exp_cyc,
                        input logic [63:0] exp_res, input int abort_cyc,
                        input bit abort_rst);
    int done_cyc = 0;
    int bad_cyc = 0;
    logic exp_stall;
    @(posedge clk); #1;
    valid = 1'b1; op = o; word = w; rs1 = a; rs2 = b;
    kill = 1'b0; rst = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        rs1 = {$urandom, $urandom};
        rs2 = {$urandom, $urandom};
        kill = 1'b0;
        rst = 1'b0;
        if (abort_cyc != 0 && c >= abort_cyc) valid = 1'b0;
        if (c == abort_cyc) begin
          if (abort_rst) rst = 1'b1;
          else kill = 1'b1;
        end
      end
      @(negedge clk);
      if (abort_cyc != 0 && c >= abort_cyc) exp_stall = 1'b0;
      else exp_stall = (c < exp_cyc);
      if (stall !== exp_stall && bad_cyc == 0) bad_cyc = c;
      if (done === 1'b1 && done_cyc == 0) done_cyc = c;
      if (abort_rst && abort_cyc != 0 && c == abort_cyc + 1) begin
        chk({nm, " post-rst result"}, result, 64'd0);
        chk({nm, " post-rst done"}, {63'd0, done}, 64'd0);
      end
      if (abort_cyc == 0 && c == exp_cyc) break;
    end
    chk({nm, " first bad stall cycle"}, 64'(bad_cyc), 64'd0);
    if (abort_cyc == 0) begin
      chk({nm, " done cycle"}, 64'(done_cyc), 64'(exp_cyc));
      chk({nm, " result"}, result, exp_res);
      last_res = exp_res;
    end else begin
      chk({nm, " done cycle"}, 64'(done_cyc), 64'd0);
      if (abort_rst) last_res = '0;
      chk({nm, " result kept"}, result, last_res);
    end
  endtask

  initial begin
    vt[0]  = '{2'b00, 1'b0, 64'd100, 64'd7, 66, 64'd14};
    vt[1]  = '{2'b10, 1'b0, 64'd100, 64'd7, 66, 64'd2};
    vt[2]  = '{2'b00, 1'b1, 64'hFFFFFFFF_FFFFFF9C, 64'd7, 34,
               64'hFFFFFFFF_FFFFFFF2};
    vt[3]  = '{2'b10, 1'b1, 64'hFFFFFFFF_FFFFFF9C, 64'd7, 34,
               64'hFFFFFFFF_FFFFFFFE};
    vt[4]  = '{2'b01, 1'b0, 64'd5, 64'd0, 2, 64'hFFFFFFFF_FFFFFFFF};
    vt[5]  = '{2'b11, 1'b1, 64'h1_80000000, 64'd0, 2,
               64'hFFFFFFFF_80000000};
    vt[6]  = '{2'b00, 1'b0, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF,
               2, 64'h80000000_00000000};
    vt[7]  = '{2'b10, 1'b0, 64'h80000000_00000000, 64'hFFFFFFFF_FFFFFFFF,
               2, 64'd0};
    vt[8]  = '{2'b01, 1'b1, 64'h00000000_FFFFFFFF, 64'd2, 34,
               64'h00000000_7FFFFFFF};
    vt[9]  = '{2'b11, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'd10, 66, 64'd5};
    vt[10] = '{2'b00, 1'b0, 64'hFFFFFFFF_FFFFFFF9, 64'd2, 66,
               64'hFFFFFFFF_FFFFFFFD};
    vt[11] = '{2'b10, 1'b0, 64'hFFFFFFFF_FFFFFFF9, 64'd2, 66,
               64'hFFFFFFFF_FFFFFFFF};
    vt[12] = '{2'b00, 1'b1, 64'h12345678_80000000, 64'h0000_0000_FFFFFFFF,
               2, 64'hFFFFFFFF_80000000};
    vt[13] = '{2'b10, 1'b1, 64'h00000000_FFFFFFF9, 64'hABCD_0000_0000_0000,
               2, 64'hFFFFFFFF_FFFFFFF9};

    rst = 1'b1; valid = 1'b1; op = 2'b00; word = 1'b0;
    rs1 = 64'd100; rs2 = 64'd7; kill = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset stall", {63'd0, stall}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("v%0d", i), vt[i].op, vt[i].w, vt[i].a, vt[i].b,
             vt[i].cyc, vt[i].res, 0, 1'b0);

    run_op("kill DIVU", 2'b01, 1'b0, 64'd1000, 64'd3, 66, 64'd333,
           10, 1'b0);
    run_op("DIVUW after kill", 2'b01, 1'b1, 64'h80000000, 64'd1, 34,
           64'hFFFFFFFF_80000000, 0, 1'b0);
    run_op("rst DIV", 2'b00, 1'b0, 64'd100, 64'd7, 66, 64'd14,
           20, 1'b1);
    run_op("DIV after rst", 2'b00, 1'b0, 64'd100, 64'd7, 66, 64'd14,
           0, 1'b0);

    @(posedge clk); #1;
    valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
